// File: rtl/regfile_param.sv
// Parameterised register file with a snapshot-and-dump FSM.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_param #(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 5,
    parameter int          SP_IDX     = 29,
    parameter logic [31:0] SP_INIT    = 32'h00000FFF,
    parameter int          RESULT_IDX = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              finish,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done,
    output logic [DATA_W-1:0] result
);

    localparam int                NREG     = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] SP_RST   = DATA_W'(SP_INIT);
    localparam logic [ADDR_W-1:0] RES_ADDR = ADDR_W'(RESULT_IDX);

    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] regs [NREG];
    logic [ADDR_W-1:0] idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == SP_IDX) ? SP_RST : '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
`ifdef REGFILE_BYPASS_EN
        if (we && waddr != '0 && raddr1 == waddr)
            rdata1 = wdata;
        if (we && waddr != '0 && raddr2 == waddr)
            rdata2 = wdata;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (finish) state_next = DUMP;
            DUMP:    if (dump_ready && idx == '1) state_next = DONE;
            DONE:    if (!finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The last beat leaves idx parked at NREG-1 rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx    <= '0;
            result <= '0;
        end else if (state == IDLE && finish) begin
            idx    <= '0;
            result <= regs[RES_ADDR];
        end else if (state == DUMP && dump_ready && idx != '1) begin
            idx <= idx + 1'b1;
        end
    end

    assign dump_valid = (state == DUMP);
    assign dump_done  = (state == DONE);
    assign dump_addr  = idx;
    assign dump_data  = (idx == '0) ? '0 : regs[idx];

endmodule

// File: tb/tb_regfile_param.sv
// Directed testbench for regfile_param: reset, writes, forwarding, dump FSM.
// Expectations follow the REGFILE_BYPASS_EN setting of the build.
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        finish;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [32];

    regfile_param dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .finish     (finish),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++)
            model[i] = (i == 29) ? 32'h00000FFF : 32'h0;
    endtask

    // Tasks start and end 1 time unit after a rising edge.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    task automatic test_reset();
        reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = 5'd29; raddr2 = 5'd0; finish = 1'b0; dump_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rdata1 !== 32'h00000FFF) begin errors++; $display("[TB] FAIL reset_sp: got %h expected %h", rdata1, 32'h00000FFF); end
        checks++;
        if (rdata2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_r0: got %h expected %h", rdata2, 32'h0); end
        checks++;
        if (dump_valid !== 1'b0 || dump_done !== 1'b0 || result !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_outputs: got valid=%b done=%b result=%h expected 0 0 0", dump_valid, dump_done, result);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); #1;
            checks++;
            if (rdata1 !== model[i]) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", i, rdata1, model[i]); end
        end
    endtask

    task automatic test_write();
        write_reg(5'd0, 32'hDEADBEEF);
        raddr1 = 5'd0; #1;
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("[TB] FAIL write_r0: got %h expected %h", rdata1, 32'h0); end
        write_reg(5'd5, 32'h12345678);
        raddr1 = 5'd5; raddr2 = 5'd5; #1;
        checks++;
        if (rdata1 !== 32'h12345678) begin errors++; $display("[TB] FAIL write_r5_p1: got %h expected %h", rdata1, 32'h12345678); end
        checks++;
        if (rdata2 !== 32'h12345678) begin errors++; $display("[TB] FAIL write_r5_p2: got %h expected %h", rdata2, 32'h12345678); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_fwd;
`ifdef REGFILE_BYPASS_EN
        exp_fwd = 32'hA5A5A5A5;
`else
        exp_fwd = 32'h0;
`endif
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr1 = 5'd7; #1;
        checks++;
        if (rdata1 !== exp_fwd) begin errors++; $display("[TB] FAIL bypass_same_cycle: got %h expected %h", rdata1, exp_fwd); end
        @(posedge clk); #1;
        we = 1'b0; model[7] = 32'hA5A5A5A5; #1;
        checks++;
        if (rdata1 !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL bypass_after_edge: got %h expected %h", rdata1, 32'hA5A5A5A5); end
    endtask

    task automatic test_back_to_back();
        write_reg(5'd3, 32'h00000033);
        write_reg(5'd4, 32'h00000044);
        raddr1 = 5'd3; raddr2 = 5'd4; #1;
        checks++;
        if (rdata1 !== 32'h33 || rdata2 !== 32'h44) begin
            errors++; $display("[TB] FAIL back_to_back: got %h/%h expected 00000033/00000044", rdata1, rdata2);
        end
    endtask

    task automatic test_dump();
        int beats = 0;
        write_reg(5'd2, 32'h0000002A);
        finish = 1'b1;
        for (int cyc = 0; cyc < 200 && beats < 32; cyc++) begin
            @(posedge clk); #1;
            dump_ready = (cyc % 2) == 1;
            @(negedge clk);
            if (dump_done === 1'b1) begin
                checks++; errors++;
                $display("[TB] FAIL dump_early_done: got done=%b valid=%b expected done=0", dump_done, dump_valid);
            end
            if (dump_valid === 1'b1) begin
                checks++;
                if (dump_addr !== 5'(beats)) begin errors++; $display("[TB] FAIL dump_addr: got %0d expected %0d", dump_addr, beats); end
                checks++;
                if (dump_data !== model[beats]) begin errors++; $display("[TB] FAIL dump_data%0d: got %h expected %h", beats, dump_data, model[beats]); end
                if (dump_ready) beats++;
            end
        end
        checks++;
        if (beats != 32) begin errors++; $display("[TB] FAIL dump_beats: got %0d expected 32", beats); end
        @(posedge clk); #1;
        dump_ready = 1'b0;
        checks++;
        if (dump_valid !== 1'b0 || dump_done !== 1'b1) begin
            errors++; $display("[TB] FAIL dump_done_state: got valid=%b done=%b expected 0 1", dump_valid, dump_done);
        end
        checks++;
        if (result !== 32'h0000002A) begin errors++; $display("[TB] FAIL dump_result: got %h expected %h", result, 32'h2A); end
        write_reg(5'd2, 32'h00000055);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dump_done !== 1'b1 || result !== 32'h0000002A) begin
            errors++; $display("[TB] FAIL done_hold: got done=%b result=%h expected 1 0000002a", dump_done, result);
        end
        finish = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL done_release: got done=%b valid=%b expected 0 0", dump_done, dump_valid);
        end
    endtask

    task automatic test_finish_drop();
        int beats = 0;
        finish = 1'b1; dump_ready = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        checks++;
        if (result !== 32'h00000055) begin errors++; $display("[TB] FAIL drop_result: got %h expected %h", result, 32'h55); end
        for (int cyc = 0; cyc < 100 && beats < 32; cyc++) begin
            @(negedge clk);
            if (dump_valid === 1'b1) beats++;
            @(posedge clk); #1;
        end
        checks++;
        if (beats != 32) begin errors++; $display("[TB] FAIL drop_beats: got %0d expected 32", beats); end
        checks++;
        if (dump_done !== 1'b1) begin errors++; $display("[TB] FAIL drop_done: got %b expected 1", dump_done); end
        @(posedge clk); #1;
        checks++;
        if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL drop_idle: got done=%b valid=%b expected 0 0", dump_done, dump_valid);
        end
        dump_ready = 1'b0;
    endtask

    task automatic test_reset_mid_dump();
        bit reached = 1'b0;
        finish = 1'b1; dump_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && !reached; cyc++) begin
            @(negedge clk);
            if (dump_valid === 1'b1 && dump_addr === 5'd10) reached = 1'b1;
        end
        checks++;
        if (!reached) begin errors++; $display("[TB] FAIL abort_reach_beat10: got %b expected 1", reached); end
        reset = 1'b0; dump_ready = 1'b0; #1;
        model_reset();
        checks++;
        if (dump_valid !== 1'b0 || dump_done !== 1'b0 || result !== 32'h0) begin
            errors++; $display("[TB] FAIL abort_outputs: got valid=%b done=%b result=%h expected 0 0 0", dump_valid, dump_done, result);
        end
        raddr1 = 5'd2; raddr2 = 5'd29; #1;
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h00000FFF) begin
            errors++; $display("[TB] FAIL abort_regs: got %h/%h expected 00000000/00000fff", rdata1, rdata2);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dump_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_beats: got %b expected 0", dump_valid); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dump_valid !== 1'b1 || dump_addr !== 5'd0 || dump_data !== 32'h0) begin
            errors++; $display("[TB] FAIL restart: got valid=%b addr=%0d data=%h expected 1 0 00000000", dump_valid, dump_addr, dump_data);
        end
        finish = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_bypass();
        test_back_to_back();
        test_dump();
        test_finish_drop();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
